multicycle_ctrl: RTL and testbench

Parametrised multi-cycle MIPS controller FSM. It is the successor to the team's single-cycle control signal generator and accepts the same one-hot decoded opcode inputs (RT, addi, andi, lw, sw, j, jal, jr, beq, bne). It sequences each instruction over 3–5 cycles and generates Moore-style datapath controls per state. It adds a memory-ready handshake with a stall timeout and a sticky error state.

---
 rtl/multicycle_ctrl.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle MIPS control FSM.
//
// Each instruction takes 3 to 5 cycles. The block produces Moore-style datapath controls for
// each state. FETCH, MEM_RD and MEM_WR wait for mem_ready. If mem_ready stays low for too
// long in one of these states, the FSM moves to a sticky ERROR state.
//
// Parameters
//   ALUOP_W      width of ALUOp (>= 2); the 2-bit encodings are zero-extended
//   TIMEOUT_CYC  consecutive stall cycles in a memory state before ERROR; 0 disables
//
// Ports
//   clk, rst                    clock (rising edge), asynchronous active-low reset
//   RT .. bne                   one-hot decoded opcode, sampled only in DECODE
//   mem_ready                   memory access completes this cycle
//   PCWrite, PCWriteCond        unconditional / branch PC write
//   BranchNe                    branch on not-equal
//   PCSrc                       00 ALU, 01 ALUOut, 10 jump target, 11 register
//   IorD, IRWrite               memory address select, instruction register latch
//   ALUSrcA, ALUSrcB, ALUOp     ALU operand and operation selects
//   RegDst                      00 rt, 01 rd, 10 r31
//   RegWrite, MemRead, MemWrite, MemToReg, WDInp   register file / memory strobes
//   instr_done                  pulse on the final cycle of each instruction
//   illegal_op                  pulse when DECODE sees no opcode
//   bus_error                   high while in ERROR (left only through reset)
//   state_o                     current state, encoding below
//
// State encoding on state_o:
//   0 FETCH, 1 DECODE, 2 EXEC_R, 3 WB_R, 4 EXEC_I, 5 WB_I, 6 MEM_ADDR, 7 MEM_RD,
//   8 MEM_WB, 9 MEM_WR, 10 BRANCH, 11 JUMP, 12 JAL, 13 JR, 14 ERROR

module multicycle_ctrl #(
    parameter int unsigned ALUOP_W     = 2,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               RT,
    input  logic               addi,
    input  logic               andi,
    input  logic               lw,
    input  logic               sw,
    input  logic               j,
    input  logic               jal,
    input  logic               jr,
    input  logic               beq,
    input  logic               bne,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               BranchNe,
    output logic [1:0]         PCSrc,
    output logic               IorD,
    output logic               IRWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [1:0]         RegDst,
    output logic               RegWrite,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               MemToReg,
    output logic               WDInp,
    output logic               instr_done,
    output logic               illegal_op,
    output logic               bus_error,
    output logic [3:0]         state_o
);

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StExecR   = 4'd2,
        StWbR     = 4'd3,
        StExecI   = 4'd4,
        StWbI     = 4'd5,
        StMemAddr = 4'd6,
        StMemRd   = 4'd7,
        StMemWb   = 4'd8,
        StMemWr   = 4'd9,
        StBranch  = 4'd10,
        StJump    = 4'd11,
        StJal     = 4'd12,
        StJr      = 4'd13,
        StError   = 4'd14
    } state_e;

    typedef enum logic [3:0] {
        ClsNone, ClsR, ClsAddi, ClsAndi, ClsLw, ClsSw, ClsBeq, ClsBne, ClsJal, ClsJ, ClsJr
    } cls_e;

    localparam logic [1:0] AluAdd   = 2'b00;
    localparam logic [1:0] AluSub   = 2'b01;
    localparam logic [1:0] AluFunct = 2'b10;
    localparam logic [1:0] AluAnd   = 2'b11;

    // The counter only needs to reach TIMEOUT_CYC-1; the next stall then trips ERROR.
    localparam int unsigned CntW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);

    state_e          state_q, state_d;
    cls_e            cls_q, cls_d;
    cls_e            dec_cls;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            stall;
    logic            timeout_hit;

    // Opcode priority decoder. When several inputs are high, the highest-priority one wins.
    always_comb begin
        dec_cls = ClsNone;
        if (RT)        dec_cls = ClsR;
        else if (addi) dec_cls = ClsAddi;
        else if (andi) dec_cls = ClsAndi;
        else if (lw)   dec_cls = ClsLw;
        else if (sw)   dec_cls = ClsSw;
        else if (beq)  dec_cls = ClsBeq;
        else if (bne)  dec_cls = ClsBne;
        else if (jal)  dec_cls = ClsJal;
        else if (j)    dec_cls = ClsJ;
        else if (jr)   dec_cls = ClsJr;
    end

    assign cls_d = (state_q == StDecode) ? dec_cls : cls_q;

    // Stall timeout. The count is cleared by any cycle that is not a stall. This covers both
    // mem_ready=1 and leaving the memory state.
    assign stall = ((state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr)) &&
                   !mem_ready;
    assign timeout_hit = (TIMEOUT_CYC != 0) && stall && (cnt_q == CntLast);

    always_comb begin
        cnt_d = '0;
        if ((TIMEOUT_CYC != 0) && stall) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch: begin
                if (timeout_hit)    state_d = StError;
                else if (mem_ready) state_d = StDecode;
            end
            StDecode: begin
                case (dec_cls)
                    ClsR:           state_d = StExecR;
                    ClsAddi, ClsAndi: state_d = StExecI;
                    ClsLw, ClsSw:   state_d = StMemAddr;
                    ClsBeq, ClsBne: state_d = StBranch;
                    ClsJal:         state_d = StJal;
                    ClsJ:           state_d = StJump;
                    ClsJr:          state_d = StJr;
                    default:        state_d = StFetch;
                endcase
            end
            StExecR:   state_d = StWbR;
            StWbR:     state_d = StFetch;
            StExecI:   state_d = StWbI;
            StWbI:     state_d = StFetch;
            StMemAddr: state_d = (cls_q == ClsLw) ? StMemRd : StMemWr;
            StMemRd: begin
                if (timeout_hit)    state_d = StError;
                else if (mem_ready) state_d = StMemWb;
            end
            StMemWb:   state_d = StFetch;
            StMemWr: begin
                if (timeout_hit)    state_d = StError;
                else if (mem_ready) state_d = StFetch;
            end
            StBranch, StJump, StJal, StJr: state_d = StFetch;
            StError:   state_d = StError;
            default:   state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StFetch;
            cls_q   <= ClsNone;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            cnt_q   <= cnt_d;
        end
    end

    // Output decode. Everything is held at 0 while rst is low. Reset is asynchronous, so the
    // write strobes drop immediately and do not wait for a clock edge.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        BranchNe    = 1'b0;
        PCSrc       = 2'b00;
        IorD        = 1'b0;
        IRWrite     = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = ALUOP_W'(AluAdd);
        RegDst      = 2'b00;
        RegWrite    = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemToReg    = 1'b0;
        WDInp       = 1'b0;
        instr_done  = 1'b0;
        illegal_op  = 1'b0;
        bus_error   = 1'b0;
        state_o     = 4'd0;
        if (rst) begin
            state_o = state_q;
            case (state_q)
                StFetch: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    // The instruction word and PC+4 are committed only on the cycle the fetch
                    // completes.
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                StDecode: begin
                    ALUSrcB    = 2'b11;
                    illegal_op = (dec_cls == ClsNone);
                end
                StExecR: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = ALUOP_W'(AluFunct);
                end
                StWbR: begin
                    RegDst     = 2'b01;
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                end
                StExecI: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    ALUOp   = (cls_q == ClsAndi) ? ALUOP_W'(AluAnd) : ALUOP_W'(AluAdd);
                end
                StWbI: begin
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                end
                StMemAddr: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                StMemRd: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                StMemWb: begin
                    RegWrite   = 1'b1;
                    MemToReg   = 1'b1;
                    instr_done = 1'b1;
                end
                StMemWr: begin
                    MemWrite   = 1'b1;
                    IorD       = 1'b1;
                    instr_done = mem_ready;
                end
                StBranch: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = ALUOP_W'(AluSub);
                    PCWriteCond = 1'b1;
                    PCSrc       = 2'b01;
                    BranchNe    = (cls_q == ClsBne);
                    instr_done  = 1'b1;
                end
                StJump: begin
                    PCWrite    = 1'b1;
                    PCSrc      = 2'b10;
                    instr_done = 1'b1;
                end
                StJal: begin
                    PCWrite    = 1'b1;
                    PCSrc      = 2'b10;
                    RegWrite   = 1'b1;
                    RegDst     = 2'b10;
                    WDInp      = 1'b1;
                    instr_done = 1'b1;
                end
                StJr: begin
                    PCWrite    = 1'b1;
                    PCSrc      = 2'b11;
                    instr_done = 1'b1;
                end
                StError: begin
                    bus_error = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl. Instructions are sequenced with random opcodes and random memory
// stalls. Every cycle is compared with a per-instruction phase sequence built from the
// instruction class.

module tb_multicycle_ctrl;

    localparam int unsigned AW = 3;
    localparam int unsigned TO = 4;

    // Opcode bit positions, ordered by decode priority (lowest index wins).
    localparam int C_R = 0, C_ADDI = 1, C_ANDI = 2, C_LW = 3, C_SW = 4;
    localparam int C_BEQ = 5, C_BNE = 6, C_JAL = 7, C_J = 8, C_JR = 9, C_ILL = 10;

    typedef enum int {
        PhFetch, PhDecode, PhExR, PhWbR, PhExI, PhWbI, PhMa, PhMrd, PhMwb, PhMwr,
        PhBr, PhJmp, PhJal, PhJr, PhErr
    } ph_e;

    typedef struct packed {
        logic          pcw;
        logic          pcwc;
        logic          brne;
        logic [1:0]    pcsrc;
        logic          iord;
        logic          irw;
        logic          srca;
        logic [1:0]    srcb;
        logic [AW-1:0] aluop;
        logic [1:0]    regdst;
        logic          regw;
        logic          memr;
        logic          memw;
        logic          m2r;
        logic          wdinp;
        logic          done;
        logic          ill;
        logic          buserr;
    } ctrl_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [9:0]    opv = '0;
    logic          mem_ready = 1'b0;
    logic          PCWrite, PCWriteCond, BranchNe, IorD, IRWrite, ALUSrcA;
    logic [1:0]    PCSrc, ALUSrcB, RegDst;
    logic [AW-1:0] ALUOp;
    logic          RegWrite, MemRead, MemWrite, MemToReg, WDInp;
    logic          instr_done, illegal_op, bus_error;
    logic [3:0]    state_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(
        .ALUOP_W     (AW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .RT          (opv[C_R]),
        .addi        (opv[C_ADDI]),
        .andi        (opv[C_ANDI]),
        .lw          (opv[C_LW]),
        .sw          (opv[C_SW]),
        .j           (opv[C_J]),
        .jal         (opv[C_JAL]),
        .jr          (opv[C_JR]),
        .beq         (opv[C_BEQ]),
        .bne         (opv[C_BNE]),
        .mem_ready   (mem_ready),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .BranchNe    (BranchNe),
        .PCSrc       (PCSrc),
        .IorD        (IorD),
        .IRWrite     (IRWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .RegDst      (RegDst),
        .RegWrite    (RegWrite),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .MemToReg    (MemToReg),
        .WDInp       (WDInp),
        .instr_done  (instr_done),
        .illegal_op  (illegal_op),
        .bus_error   (bus_error),
        .state_o     (state_o)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic ctrl_t sample();
        ctrl_t c;
        c.pcw = PCWrite;   c.pcwc = PCWriteCond; c.brne = BranchNe; c.pcsrc = PCSrc;
        c.iord = IorD;     c.irw = IRWrite;      c.srca = ALUSrcA;  c.srcb = ALUSrcB;
        c.aluop = ALUOp;   c.regdst = RegDst;    c.regw = RegWrite; c.memr = MemRead;
        c.memw = MemWrite; c.m2r = MemToReg;     c.wdinp = WDInp;   c.done = instr_done;
        c.ill = illegal_op; c.buserr = bus_error;
        return c;
    endfunction

    function automatic int first_set(input logic [9:0] v);
        for (int i = 0; i < 10; i++) if (v[i]) return i;
        return C_ILL;
    endfunction

    // Expected controls for one cycle, taken directly from the per-state control list.
    function automatic ctrl_t exp_ctrl(input ph_e ph, input int cls, input logic rdy,
                                       input logic done, input logic ill);
        ctrl_t c;
        c = '0;
        case (ph)
            PhFetch: begin c.memr = 1; c.srcb = 2'b01; c.irw = rdy; c.pcw = rdy; end
            PhDecode: c.srcb = 2'b11;
            PhExR: begin c.srca = 1; c.aluop = AW'(2); end
            PhWbR: begin c.regdst = 2'b01; c.regw = 1; end
            PhExI: begin c.srca = 1; c.srcb = 2'b10; c.aluop = (cls == C_ANDI) ? AW'(3) : '0; end
            PhWbI: c.regw = 1;
            PhMa:  begin c.srca = 1; c.srcb = 2'b10; end
            PhMrd: begin c.memr = 1; c.iord = 1; end
            PhMwb: begin c.regw = 1; c.m2r = 1; end
            PhMwr: begin c.memw = 1; c.iord = 1; end
            PhBr: begin
                c.srca = 1; c.aluop = AW'(1); c.pcwc = 1; c.pcsrc = 2'b01;
                c.brne = (cls == C_BNE);
            end
            PhJmp: begin c.pcw = 1; c.pcsrc = 2'b10; end
            PhJal: begin c.pcw = 1; c.pcsrc = 2'b10; c.regw = 1; c.regdst = 2'b10; c.wdinp = 1; end
            PhJr:  begin c.pcw = 1; c.pcsrc = 2'b11; end
            PhErr: c.buserr = 1;
            default: c = '0;
        endcase
        c.done = done;
        c.ill  = ill;
        return c;
    endfunction

    // Runs one clock cycle: drive the inputs, compare at the falling edge, then step past
    // the next rising edge.
    task automatic cycle(input ph_e ph, input int cls, input logic rdy, input logic [9:0] ops,
                         input logic done, input logic ill, input string tag);
        ctrl_t got, exp;
        mem_ready = rdy;
        opv = ops;
        @(negedge clk);
        got = sample();
        exp = exp_ctrl(ph, cls, rdy, done, ill);
        check_eq({tag, ".ctrl"}, 64'(got), 64'(exp));
        check_eq({tag, ".state"}, 64'(state_o), 64'(ph));
        @(posedge clk);
        #1;
    endtask

    task automatic mem_wait(input ph_e ph, input int cls, input int stalls, input logic last,
                            input string tag);
        for (int s = 0; s < stalls; s++) cycle(ph, cls, 1'b0, 10'($urandom), 1'b0, 1'b0, tag);
        cycle(ph, cls, 1'b1, 10'($urandom), last, 1'b0, tag);
    endtask

    task automatic run_instr(input logic [9:0] ops, input int fst, input int mst,
                             input string tag);
        int  cls;
        ph_e seq[$];
        mem_wait(PhFetch, 0, fst, 1'b0, tag);
        cls = first_set(ops);
        cycle(PhDecode, cls, 1'($urandom), ops, 1'b0, cls == C_ILL, tag);
        if (cls == C_ILL) return;
        case (cls)
            C_R:            seq = '{PhExR, PhWbR};
            C_ADDI, C_ANDI: seq = '{PhExI, PhWbI};
            C_LW:           seq = '{PhMa, PhMrd, PhMwb};
            C_SW:           seq = '{PhMa, PhMwr};
            C_BEQ, C_BNE:   seq = '{PhBr};
            C_JAL:          seq = '{PhJal};
            C_J:            seq = '{PhJmp};
            default:        seq = '{PhJr};
        endcase
        foreach (seq[i]) begin
            if (seq[i] == PhMrd || seq[i] == PhMwr)
                mem_wait(seq[i], cls, mst, i == seq.size() - 1, tag);
            else
                cycle(seq[i], cls, 1'($urandom), 10'($urandom), i == seq.size() - 1, 1'b0, tag);
        end
    endtask

    function automatic logic [9:0] onehot(input int b);
        logic [9:0] v;
        v = '0;
        v[b] = 1'b1;
        return v;
    endfunction

    initial begin
        ctrl_t      got;
        logic [9:0] ops;
        int         r, fst, mst;

        // Reset: everything is forced low, including the FETCH controls.
        mem_ready = 1'b1;
        opv = 10'($urandom);
        #3;
        got = sample();
        check_eq("reset.ctrl", 64'(got), 64'(0));
        check_eq("reset.state", 64'(state_o), 64'(PhFetch));
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Directed cases
        run_instr(onehot(C_R), 0, 0, "r_type");
        run_instr(onehot(C_LW), 0, 3, "lw_stall");
        run_instr(onehot(C_BNE), 0, 0, "bne");
        run_instr(onehot(C_JAL), 0, 0, "jal");
        run_instr(onehot(C_R) | onehot(C_LW), 0, 0, "prio_r_lw");
        run_instr('0, 0, 0, "illegal");
        run_instr(onehot(C_SW), 2, 1, "sw_stall");
        run_instr(onehot(C_ANDI), 0, 0, "andi");

        // Random instruction stream. Stalls stay below the timeout.
        for (int n = 0; n < 200; n++) begin
            r = int'($urandom_range(0, 15));
            if (r < 10)       ops = onehot(r);
            else if (r < 13)  ops = 10'($urandom);
            else if (r == 13) ops = '0;
            else              ops = onehot(int'($urandom_range(0, 9)));
            fst = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, TO - 1)) : 0;
            mst = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, TO - 1)) : 0;
            run_instr(ops, fst, mst, "rand");
        end

        // Timeout: TO consecutive stalls in FETCH, then ERROR holds regardless of mem_ready.
        for (int s = 0; s < int'(TO); s++)
            cycle(PhFetch, 0, 1'b0, 10'($urandom), 1'b0, 1'b0, "timeout_fetch");
        for (int s = 0; s < 4; s++)
            cycle(PhErr, 0, 1'($urandom), 10'($urandom), 1'b0, 1'b0, "error_hold");
        rst = 1'b0;
        #1;
        got = sample();
        check_eq("error_reset.ctrl", 64'(got), 64'(0));
        check_eq("error_reset.bus_error", 64'(bus_error), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b1;
        run_instr(onehot(C_J), 0, 0, "after_error");

        // Async reset asserted during MEM_WR: MemWrite must drop without a clock edge.
        cycle(PhFetch, 0, 1'b1, 10'($urandom), 1'b0, 1'b0, "sw_rst");
        cycle(PhDecode, C_SW, 1'b1, onehot(C_SW), 1'b0, 1'b0, "sw_rst");
        cycle(PhMa, C_SW, 1'b1, 10'($urandom), 1'b0, 1'b0, "sw_rst");
        mem_ready = 1'b0;
        @(negedge clk);
        check_eq("midwr.memwrite_before", 64'(MemWrite), 64'(1));
        #2;
        rst = 1'b0;
        #1;
        check_eq("midwr.memwrite_after", 64'(MemWrite), 64'(0));
        got = sample();
        check_eq("midwr.ctrl", 64'(got), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b1;
        run_instr(onehot(C_JR), 0, 0, "after_midwr");
        run_instr(onehot(C_ADDI), 1, 0, "after_midwr2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
